// File: rtl/rominit_sink.sv
// rtl/rominit_sink.sv - ROMINIT byte-stream sink: beat FIFO, boot/chr ROM writer, load tracking
module rominit_sink #(
  parameter int DEPTH   = 4,
  parameter int BOOT_AW = 12,
  parameter int CHR_AW  = 9
) (
  input  logic               CLK_SYS,
  input  logic               RESET,
  input  logic               ROMINIT_SEL_BOOT,
  input  logic               ROMINIT_SEL_CHR,
  input  logic [11:0]        ROMINIT_ADDR,
  input  logic [7:0]         ROMINIT_DATA,
  input  logic               ROMINIT_VALID,
  output logic               ROMINIT_READY,
  input  logic               MEM_BUSY,
  output logic               BOOT_WE,
  output logic [BOOT_AW-1:0] BOOT_A,
  output logic               CHR_WE,
  output logic [CHR_AW-1:0]  CHR_A,
  output logic [7:0]         MEM_D,
  output logic               BOOT_LOADED,
  output logic               CHR_LOADED,
  output logic               CORE_HOLD,
  output logic               ERR_ADDR
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [12:0] CHR_SIZE = 13'(1) << CHR_AW;

  // FIFO storage (no reset needed: occupancy is tracked by count_q)
  logic        fifo_boot_q [DEPTH];
  logic [11:0] fifo_addr_q [DEPTH];
  logic [7:0]  fifo_data_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;

  logic               boot_we_q, chr_we_q;
  logic [BOOT_AW-1:0] boot_a_q;
  logic [CHR_AW-1:0]  chr_a_q;
  logic [7:0]         mem_d_q;
  logic               boot_loaded_q, boot_loaded_d;
  logic               chr_loaded_q, chr_loaded_d;
  logic               err_q, hold_q, hold_d;

  logic        ready, accept, legal, push, pop, addr_oob;
  logic        head_boot;
  logic [11:0] head_addr;
  logic [7:0]  head_data;

  // Handshake, input filter and FIFO head decode
  always_comb begin
    ready     = (count_q != CW'(DEPTH));
    accept    = ROMINIT_VALID & ready;
    addr_oob  = ({1'b0, ROMINIT_ADDR} >= CHR_SIZE);
    legal     = (ROMINIT_SEL_BOOT ^ ROMINIT_SEL_CHR) & ~(ROMINIT_SEL_CHR & addr_oob);
    push      = accept & legal;
    pop       = (count_q != '0) & ~MEM_BUSY;
    head_boot = fifo_boot_q[rd_ptr_q];
    head_addr = fifo_addr_q[rd_ptr_q];
    head_data = fifo_data_q[rd_ptr_q];
  end

  // Next-state for occupancy, load flags and core hold
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    boot_loaded_d = boot_loaded_q;
    chr_loaded_d  = chr_loaded_q;
    if (pop && head_boot && (head_addr[BOOT_AW-1:0] == '1))
      boot_loaded_d = 1'b1;
    if (pop && !head_boot && (head_addr[CHR_AW-1:0] == '1))
      chr_loaded_d = 1'b1;
    // A fresh address-0 beat means the image is being reloaded; it wins over a
    // completing write of the previous image since it is ordered after it.
    if (push && ROMINIT_SEL_BOOT && (ROMINIT_ADDR[BOOT_AW-1:0] == '0))
      boot_loaded_d = 1'b0;
    if (push && ROMINIT_SEL_CHR && (ROMINIT_ADDR == '0))
      chr_loaded_d = 1'b0;

    hold_d = ~(boot_loaded_q & chr_loaded_q) | (count_q != '0) | boot_we_q | chr_we_q;
  end

  // FIFO entry write on a legal accepted beat
  always_ff @(posedge CLK_SYS) begin
    if (push) begin
      fifo_boot_q[wr_ptr_q] <= ROMINIT_SEL_BOOT;
      fifo_addr_q[wr_ptr_q] <= ROMINIT_ADDR;
      fifo_data_q[wr_ptr_q] <= ROMINIT_DATA;
    end
  end

  // Control state, write port registers and status flags
  always_ff @(posedge CLK_SYS or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      boot_we_q     <= 1'b0;
      chr_we_q      <= 1'b0;
      boot_a_q      <= '0;
      chr_a_q       <= '0;
      mem_d_q       <= '0;
      boot_loaded_q <= 1'b0;
      chr_loaded_q  <= 1'b0;
      err_q         <= 1'b0;
      hold_q        <= 1'b1;
    end else begin
      count_q       <= count_d;
      boot_loaded_q <= boot_loaded_d;
      chr_loaded_q  <= chr_loaded_d;
      hold_q        <= hold_d;
      if (push)
        wr_ptr_q <= wr_ptr_q + PW'(1);
      if (accept && !legal)
        err_q <= 1'b1;
      boot_we_q <= pop & head_boot;
      chr_we_q  <= pop & ~head_boot;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        mem_d_q  <= head_data;
        if (head_boot)
          boot_a_q <= head_addr[BOOT_AW-1:0];
        else
          chr_a_q <= head_addr[CHR_AW-1:0];
      end
    end
  end

  assign ROMINIT_READY = ready;
  assign BOOT_WE       = boot_we_q;
  assign BOOT_A        = boot_a_q;
  assign CHR_WE        = chr_we_q;
  assign CHR_A         = chr_a_q;
  assign MEM_D         = mem_d_q;
  assign BOOT_LOADED   = boot_loaded_q;
  assign CHR_LOADED    = chr_loaded_q;
  assign CORE_HOLD     = hold_q;
  assign ERR_ADDR      = err_q;

endmodule

// File: tb/tb_rominit_sink.sv
// tb/tb_rominit_sink.sv - scoreboard bench for rominit_sink
module tb_rominit_sink;

  logic        CLK_SYS = 1'b0;
  logic        RESET = 1'b1;
  logic        ROMINIT_SEL_BOOT = 1'b0;
  logic        ROMINIT_SEL_CHR = 1'b0;
  logic [11:0] ROMINIT_ADDR = '0;
  logic [7:0]  ROMINIT_DATA = '0;
  logic        ROMINIT_VALID = 1'b0;
  logic        ROMINIT_READY;
  logic        MEM_BUSY = 1'b0;
  logic        BOOT_WE;
  logic [11:0] BOOT_A;
  logic        CHR_WE;
  logic [8:0]  CHR_A;
  logic [7:0]  MEM_D;
  logic        BOOT_LOADED, CHR_LOADED, CORE_HOLD, ERR_ADDR;

  rominit_sink dut (
    .CLK_SYS(CLK_SYS), .RESET(RESET),
    .ROMINIT_SEL_BOOT(ROMINIT_SEL_BOOT), .ROMINIT_SEL_CHR(ROMINIT_SEL_CHR),
    .ROMINIT_ADDR(ROMINIT_ADDR), .ROMINIT_DATA(ROMINIT_DATA),
    .ROMINIT_VALID(ROMINIT_VALID), .ROMINIT_READY(ROMINIT_READY),
    .MEM_BUSY(MEM_BUSY),
    .BOOT_WE(BOOT_WE), .BOOT_A(BOOT_A), .CHR_WE(CHR_WE), .CHR_A(CHR_A),
    .MEM_D(MEM_D), .BOOT_LOADED(BOOT_LOADED), .CHR_LOADED(CHR_LOADED),
    .CORE_HOLD(CORE_HOLD), .ERR_ADDR(ERR_ADDR)
  );

  always #5 CLK_SYS = ~CLK_SYS;

  int          n_chk = 0;
  int          n_err = 0;
  int          wr_count = 0;
  logic [20:0] sb[$];
  bit          busy_rand = 1'b0;
  bit          busy_force = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // MEM_BUSY driver: forced level or random per cycle
  always @(posedge CLK_SYS) begin
    #2;
    MEM_BUSY = busy_rand ? 1'($urandom_range(0, 1)) : busy_force;
  end

  // Write checker and acceptance model
  always @(negedge CLK_SYS) begin
    logic [20:0] e;
    logic [20:0] o;
    if (!RESET) begin
      if (BOOT_WE || CHR_WE) begin
        wr_count++;
        chk("we_onehot", 32'(BOOT_WE & CHR_WE), 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          o = {BOOT_WE, (BOOT_WE ? BOOT_A : {3'b000, CHR_A}), MEM_D};
          chk("write", 32'(o), 32'(e));
        end
        if (BOOT_WE && BOOT_A == 12'hFFF) chk("boot_loaded_at_last", 32'(BOOT_LOADED), 32'd1);
        if (CHR_WE && CHR_A == 9'h1FF) begin
          chk("chr_loaded_at_last", 32'(CHR_LOADED), 32'd1);
          chk("hold_during_last", 32'(CORE_HOLD), 32'd1);
        end
      end
      if (ROMINIT_VALID && ROMINIT_READY && (ROMINIT_SEL_BOOT != ROMINIT_SEL_CHR) &&
          !(ROMINIT_SEL_CHR && ROMINIT_ADDR >= 12'h200)) begin
        if (ROMINIT_SEL_BOOT) sb.push_back({1'b1, ROMINIT_ADDR, ROMINIT_DATA});
        else                  sb.push_back({1'b0, 3'b000, ROMINIT_ADDR[8:0], ROMINIT_DATA});
      end
    end
  end

  task automatic step();
    @(posedge CLK_SYS);
    #1;
  endtask

  task automatic drive(input logic b, input logic c, input logic [11:0] a, input logic [7:0] d);
    ROMINIT_SEL_BOOT = b;
    ROMINIT_SEL_CHR  = c;
    ROMINIT_ADDR     = a;
    ROMINIT_DATA     = d;
    ROMINIT_VALID    = 1'b1;
  endtask

  task automatic send(input logic b, input logic c, input logic [11:0] a, input logic [7:0] d);
    int t = 0;
    drive(b, c, a, d);
    @(negedge CLK_SYS);
    while (!ROMINIT_READY && t < 1000) begin
      @(negedge CLK_SYS);
      t++;
    end
    if (t >= 1000) chk("ready_timeout", 32'd0, 32'd1);
    step();
    ROMINIT_VALID = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 2000) begin
      step();
      t++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int base;
    // Reset state
    step();
    step();
    chk("rst_ready", 32'(ROMINIT_READY), 32'd1);
    chk("rst_we", 32'({BOOT_WE, CHR_WE}), 32'd0);
    chk("rst_addr", 32'({BOOT_A, CHR_A, MEM_D}), 32'd0);
    chk("rst_loaded", 32'({BOOT_LOADED, CHR_LOADED}), 32'd0);
    chk("rst_err", 32'(ERR_ADDR), 32'd0);
    chk("rst_hold", 32'(CORE_HOLD), 32'd1);
    RESET = 1'b0;
    step();

    // 1: single boot beat latency and pulse width
    drive(1'b1, 1'b0, 12'h123, 8'hA5);
    step();
    ROMINIT_VALID = 1'b0;
    @(negedge CLK_SYS);
    chk("t1_we_early", 32'(BOOT_WE), 32'd0);
    step();
    @(negedge CLK_SYS);
    chk("t1_boot_we", 32'(BOOT_WE), 32'd1);
    chk("t1_boot_a", 32'(BOOT_A), 32'h123);
    chk("t1_mem_d", 32'(MEM_D), 32'hA5);
    chk("t1_chr_we", 32'(CHR_WE), 32'd0);
    step();
    @(negedge CLK_SYS);
    chk("t1_we_drop", 32'(BOOT_WE), 32'd0);
    chk("t1_a_hold", 32'(BOOT_A), 32'h123);

    // 2: fill while busy, back-pressure, in-order drain
    busy_force = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 12'(i), 8'(8'h10 + i));
      @(negedge CLK_SYS);
      chk("t2_ready_fill", 32'(ROMINIT_READY), 32'd1);
      step();
    end
    drive(1'b0, 1'b1, 12'd4, 8'h14);
    @(negedge CLK_SYS);
    chk("t2_full", 32'(ROMINIT_READY), 32'd0);
    step();
    busy_force = 1'b0;
    @(negedge CLK_SYS);
    chk("t2_full_hold", 32'(ROMINIT_READY), 32'd0);
    chk("t2_no_we_busy", 32'(CHR_WE), 32'd0);
    step();
    @(negedge CLK_SYS);
    chk("t2_ready_back", 32'(ROMINIT_READY), 32'd1);
    chk("t2_consec", 32'(CHR_WE), 32'd1);
    step();
    ROMINIT_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK_SYS);
      chk("t2_consec", 32'(CHR_WE), 32'd1);
      step();
    end
    drain();

    // 4: illegal beats
    chk("t4_err_pre", 32'(ERR_ADDR), 32'd0);
    base = wr_count;
    send(1'b1, 1'b1, 12'h010, 8'h55);
    @(negedge CLK_SYS);
    chk("t4_err_set", 32'(ERR_ADDR), 32'd1);
    chk("t4_ready", 32'(ROMINIT_READY), 32'd1);
    step();
    send(1'b0, 1'b1, 12'h200, 8'h66);
    send(1'b0, 1'b0, 12'h005, 8'h77);
    for (int i = 0; i < 4; i++) step();
    @(negedge CLK_SYS);
    chk("t4_no_write", 32'(wr_count - base), 32'd0);
    chk("t4_ready2", 32'(ROMINIT_READY), 32'd1);
    step();
    send(1'b1, 1'b0, 12'h007, 8'h88);
    drain();
    chk("t4_legal_write", 32'(wr_count - base), 32'd1);
    chk("t4_err_sticky", 32'(ERR_ADDR), 32'd1);

    // 3: full image streams with random MEM_BUSY
    base = wr_count;
    busy_rand = 1'b1;
    for (int a = 0; a < 4096; a++) send(1'b1, 1'b0, 12'(a), 8'($urandom));
    for (int a = 0; a < 512; a++) send(1'b0, 1'b1, 12'(a), 8'($urandom));
    drain();
    busy_rand = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("t3_writes", 32'(wr_count - base), 32'd4608);
    chk("t3_boot_loaded", 32'(BOOT_LOADED), 32'd1);
    chk("t3_chr_loaded", 32'(CHR_LOADED), 32'd1);
    chk("t3_hold_low", 32'(CORE_HOLD), 32'd0);

    // 6: reload clears only the boot flag
    busy_force = 1'b1;
    step();
    chk("t6_hold_pre", 32'(CORE_HOLD), 32'd0);
    drive(1'b1, 1'b0, 12'h000, 8'h3C);
    @(negedge CLK_SYS);
    chk("t6_boot_pre", 32'(BOOT_LOADED), 32'd1);
    step();
    ROMINIT_VALID = 1'b0;
    @(negedge CLK_SYS);
    chk("t6_boot_clr", 32'(BOOT_LOADED), 32'd0);
    chk("t6_chr_keep", 32'(CHR_LOADED), 32'd1);
    step();
    @(negedge CLK_SYS);
    chk("t6_hold", 32'(CORE_HOLD), 32'd1);
    busy_force = 1'b0;
    drain();

    // 5: reset with queued beats
    busy_force = 1'b1;
    step();
    send(1'b0, 1'b1, 12'h010, 8'h01);
    send(1'b0, 1'b1, 12'h011, 8'h02);
    send(1'b0, 1'b1, 12'h012, 8'h03);
    RESET = 1'b1;
    #1;
    chk("t5_we", 32'({BOOT_WE, CHR_WE}), 32'd0);
    chk("t5_ready", 32'(ROMINIT_READY), 32'd1);
    chk("t5_hold", 32'(CORE_HOLD), 32'd1);
    chk("t5_loaded", 32'({BOOT_LOADED, CHR_LOADED}), 32'd0);
    sb.delete();
    base = wr_count;
    busy_force = 1'b0;
    step();
    step();
    RESET = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("t5_no_writes", 32'(wr_count - base), 32'd0);
    chk("t5_hold_after", 32'(CORE_HOLD), 32'd1);
    chk("t5_loaded_after", 32'({BOOT_LOADED, CHR_LOADED}), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
